// File: rtl/mem_req_master_if.sv
// Request/response and RAM-port signal bundle for mem_req_master.
// The master modport is the initiator's view; the slave modport is the core/RAM side.
interface mem_req_master_if #(
  parameter int DWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_wr;
  logic [31:0]       mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic [DWIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_master.sv
// Load/store initiator for a single-port word RAM without byte enables.
// Partial stores become read-modify-write; every RAM cycle writes back valid data.
module mem_req_master #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rstn,
  mem_req_master_if.master  io_bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RSP  = 2'd3;

  logic [1:0]        r_state;
  logic              r_we;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [DWIDTH-1:0] r_old;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;

  logic              w_oor;
  logic              w_en;
  logic              w_rsp_valid;
  logic [DWIDTH-1:0] w_merge;
  logic              w_unused_addr_lsb;

  assign w_oor             = |io_bus.req_addr[31:AWIDTH+2];
  assign w_unused_addr_lsb = ^io_bus.req_addr[1:0];

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: data registers are reset as well; they feed outputs directly
      // and must never expose stale values after an aborted operation.
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_old   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req_valid) begin
            r_we    <= io_bus.req_we;
            r_addr  <= io_bus.req_addr[AWIDTH+1:2];
            r_wdata <= io_bus.req_wdata;
            r_be    <= io_bus.req_be;
            r_err   <= w_oor;
            r_rdata <= '0;
            if (w_oor || (io_bus.req_we && io_bus.req_be == 4'h0))
              r_state <= S_RSP;
            else if (io_bus.req_we && io_bus.req_be == 4'hF)
              r_state <= S_WR;
            else
              r_state <= S_RD;
          end
        end
        S_RD: begin
          r_old <= io_bus.mem_rdata;
          if (!r_we) begin
            r_rdata <= io_bus.mem_rdata;
            r_state <= S_RSP;
          end else begin
            r_state <= S_WR;
          end
        end
        S_WR:    r_state <= S_RSP;
        S_RSP:   if (io_bus.rsp_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the default assignment before the loop keeps this block free of latches.
  always_comb begin
    w_merge = r_old;
    for (int i = 0; i < 4; i++) begin
      if (r_be[i]) w_merge[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Outputs are gated by rstn so the port is quiet while reset is held.
  assign w_en        = rstn && (r_state == S_RD || r_state == S_WR);
  assign w_rsp_valid = rstn && (r_state == S_RSP);

  assign io_bus.req_ready = rstn && (r_state == S_IDLE);
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_rdata = w_rsp_valid ? r_rdata : '0;
  assign io_bus.rsp_err   = w_rsp_valid && r_err;
  assign io_bus.mem_en    = w_en;
  assign io_bus.mem_wr    = w_en && (r_state == S_WR);
  assign io_bus.mem_addr  = w_en ? {{(32-AWIDTH){1'b0}}, r_addr} : 32'h0;
  // The read cycle writes back what it reads, so it never corrupts the RAM.
  assign io_bus.mem_wdata = !w_en               ? '0      :
                            (r_state == S_WR)   ? w_merge :
                                                  io_bus.mem_rdata;

endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: RAM model, transaction-level reference model with
// a per-cycle output compare, directed scenarios and randomized traffic.
module tb_mem_req_master;
  localparam int AW    = 8;
  localparam int WORDS = 1 << AW;

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_req_master_if #(.DWIDTH(32)) bus ();

  mem_req_master #(.AWIDTH(AW), .DWIDTH(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .io_bus (bus)
  );

  // RAM: writes whenever enabled, combinational read.
  logic [31:0] ram   [WORDS];
  logic [31:0] g_mem [WORDS];
  assign bus.mem_rdata = ram[bus.mem_addr[AW-1:0]];
  always @(posedge clk) if (bus.mem_en) ram[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a transaction is a list of RAM cycles followed by a response.
  bit          m_busy = 1'b0;
  int          m_k;
  int          m_nram;
  logic        m_cwr [2];
  logic [31:0] m_cdata [2];
  logic [31:0] m_caddr;
  logic [AW-1:0] m_word;
  logic [31:0] m_rdata;
  logic        m_err;

  task automatic model_accept();
    logic [31:0] a, old, mask, merged;
    a       = bus.req_addr;
    m_word  = a[AW+1:2];
    m_caddr = 32'(m_word);
    old     = g_mem[m_word];
    mask    = {{8{bus.req_be[3]}}, {8{bus.req_be[2]}}, {8{bus.req_be[1]}}, {8{bus.req_be[0]}}};
    merged  = (bus.req_wdata & mask) | (old & ~mask);
    m_rdata = 32'h0;
    m_err   = 1'b0;
    if ((a >> (AW + 2)) != 0) begin
      m_nram = 0;
      m_err  = 1'b1;
    end else if (!bus.req_we) begin
      m_nram = 1; m_cwr[0] = 1'b0; m_cdata[0] = old; m_rdata = old;
    end else if (bus.req_be == 4'h0) begin
      m_nram = 0;
    end else if (bus.req_be == 4'hF) begin
      m_nram = 1; m_cwr[0] = 1'b1; m_cdata[0] = bus.req_wdata;
    end else begin
      m_nram = 2;
      m_cwr[0] = 1'b0; m_cdata[0] = old;
      m_cwr[1] = 1'b1; m_cdata[1] = merged;
    end
    m_busy = 1'b1;
    m_k    = 1;
  endtask

  // Compare on every falling edge, then advance the model to the next cycle.
  initial begin
    obs_t act, exp;
    forever begin
      @(negedge clk);
      act = '{bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
              bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata};
      exp = '0;
      if (rstn) begin
        if (!m_busy) exp.req_ready = 1'b1;
        else if (m_k <= m_nram) begin
          exp.mem_en    = 1'b1;
          exp.mem_wr    = m_cwr[m_k-1];
          exp.mem_addr  = m_caddr;
          exp.mem_wdata = m_cdata[m_k-1];
        end else begin
          exp.rsp_valid = 1'b1;
          exp.rsp_rdata = m_rdata;
          exp.rsp_err   = m_err;
        end
      end
      check($sformatf("cycle@%0t", $time), 128'(act), 128'(exp));
      if (!rstn) m_busy = 1'b0;
      else if (m_busy) begin
        if (m_k <= m_nram) begin
          if (m_cwr[m_k-1]) g_mem[m_word] = m_cdata[m_k-1];
          m_k++;
        end else if (bus.rsp_ready) m_busy = 1'b0;
      end else if (bus.req_valid) model_accept();
    end
  end

  // Captured first two cycles after acceptance and back-pressure stability.
  logic        d_en0, d_wr0, d_en1, d_wr1;
  logic [31:0] d_addr0, d_wd0, d_wd1;
  bit          bp_bad;

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold,
                        output logic [31:0] rdata, output logic err, output int lat);
    bit acc = 0, seen = 0;
    rdata = 32'h0; err = 1'b0; lat = 0; bp_bad = 0;
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_be = be; bus.rsp_ready = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      if (bus.req_ready) acc = 1;
      @(posedge clk); #2;
    end
    bus.req_valid = 1'b0;
    if (!acc) begin check("accept_timeout", 0, 1); return; end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin d_en0 = bus.mem_en; d_wr0 = bus.mem_wr; d_addr0 = bus.mem_addr; d_wd0 = bus.mem_wdata; end
      if (lat == 2) begin d_en1 = bus.mem_en; d_wr1 = bus.mem_wr; d_wd1 = bus.mem_wdata; end
      if (bus.rsp_valid) seen = 1;
    end
    if (!seen) begin check("rsp_timeout", 0, 1); return; end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    repeat (hold) begin
      @(negedge clk);
      if (bus.rsp_rdata !== rdata || bus.rsp_err !== err || !bus.rsp_valid || bus.req_ready || bus.mem_en)
        bp_bad = 1;
    end
    @(posedge clk); #2 bus.rsp_ready = 1'b1;
    @(negedge clk);
    if (bus.rsp_rdata !== rdata || !bus.rsp_valid || bus.req_ready) bp_bad = 1;
    @(posedge clk); #2 bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("ready_after_hs", bus.req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic        er, we;
    logic [3:0]  be;
    int          lat, sel;
    bit          bad;

    for (int i = 0; i < WORDS; i++) begin
      ram[i]   = $urandom;
      g_mem[i] = ram[i];
    end
    rstn = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0; bus.req_be = 4'h0; bus.rsp_ready = 1'b0;

    // Reset held with a pending request.
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.req_ready || bus.mem_en || bus.rsp_valid) bad = 1;
    end
    check("reset_quiet", bad, 0);
    @(posedge clk); #2 rstn = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1);

    // Full store then load.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
    check("st_lat", lat, 2);
    check("st_cycle", {d_en0, d_wr0, d_addr0, d_wd0}, {1'b1, 1'b1, 32'h4, 32'hDEADBEEF});
    check("st_rdata", rd, 0);
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("ld_lat", lat, 2);
    check("ld_cycle", {d_en0, d_wr0, d_wd0}, {1'b1, 1'b0, 32'hDEADBEEF});
    check("ld_rdata", rd, 32'hDEADBEEF);

    // Read-modify-write.
    do_txn(1'b1, 32'h10, 32'h11223344, 4'hF, 0, rd, er, lat);
    do_txn(1'b1, 32'h10, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat);
    check("rmw_lat", lat, 3);
    check("rmw_rd", {d_en0, d_wr0, d_wd0}, {1'b1, 1'b0, 32'h11223344});
    check("rmw_wr", {d_en1, d_wr1, d_wd1}, {1'b1, 1'b1, 32'h11BB33DD});
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    check("rmw_readback", rd, 32'h11BB33DD);

    // Zero byte enables: no RAM cycle.
    do_txn(1'b1, 32'h10, 32'h55555555, 4'h0, 0, rd, er, lat);
    check("be0_lat", lat, 1);
    check("be0_no_ram", d_en0, 0);

    // Range boundaries.
    do_txn(1'b0, 32'(4 * WORDS), 32'h0, 4'h0, 0, rd, er, lat);
    check("oor_err", {er, rd}, {1'b1, 32'h0});
    check("oor_lat", lat, 1);
    check("oor_no_ram", d_en0, 0);
    do_txn(1'b0, 32'(4 * (WORDS - 1)), 32'h0, 4'h0, 0, rd, er, lat);
    check("top_err", er, 0);
    check("top_addr", d_addr0, 32'(WORDS - 1));

    // Back-pressure on a load.
    do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
    check("bp_stable", bp_bad, 0);
    check("bp_rdata", rd, 32'h11BB33DD);

    // Reset during the read half of a read-modify-write.
    do_txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, er, lat);
    @(posedge clk); #2;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h12345678; bus.req_be = 4'b0011;
    @(negedge clk);
    check("mid_accept_ready", bus.req_ready, 1);
    @(posedge clk); #2 bus.req_valid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    check("mid_reset_no_en", bus.mem_en, 0);
    @(posedge clk); #2 rstn = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_en) bad = 1;
    end
    check("mid_reset_idle", bad, 0);
    do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
    check("mid_reset_ram", rd, 32'hCAFEF00D);

    // Randomized traffic; checked cycle by cycle against the model.
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = 32'(4 * WORDS) | 32'($urandom_range(0, 63));
        1:       a = $urandom | 32'h8000_0000;
        2:       a = 32'(4 * (WORDS - 1)) | 32'($urandom_range(0, 3));
        default: a = 32'($urandom_range(0, 63));
      endcase
      we = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 5);
      be = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom);
      do_txn(we, a, $urandom, be, $urandom_range(0, 3), rd, er, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(negedge clk);
    sel = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== g_mem[i]) sel++;
    check("ram_final", sel, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
